// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants for the fetch/decode boundary.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Control/data bundle between the IF/ID controller and its entry storage.
interface if_id_stage_if;
  import riscv_pkg::*;

  logic         push;
  logic         pop;
  logic         clear;
  fetch_entry_t wdata;
  fetch_entry_t head;

  modport master (output push, pop, clear, wdata, input head);
  modport slave  (input push, pop, clear, wdata, output head);

endinterface

// File: rtl/fetch_fifo2.sv
// Two-deep {pc, instr} storage; the owner guarantees no push when full or pop when empty.
module fetch_fifo2
  import riscv_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  if_id_stage_if.slave  fifo
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;

  // Pointer-based ring: simultaneous push/pop writes the other slot while the head advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (fifo.clear) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (fifo.push) begin
        mem_q[wr_ptr_q] <= fifo.wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (fifo.pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign fifo.head = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline buffer: 2-entry skid between fetch and decode with flush and stall counting.
module if_id_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_valid,
  input  logic            flush,
  output logic            fetch_en,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [15:0]     stall_cnt
);

  fifo_state_e state_q, state_d;
  logic [15:0] stall_cnt_q;
  logic        push;
  logic        pop;

  if_id_stage_if fifo_bus ();

  fetch_fifo2 u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .fifo   (fifo_bus.slave)
  );

  assign imem_addr = pc_in;
  assign fetch_en  = (state_q != ST_FULL);
  assign id_valid  = (state_q != ST_EMPTY) && !flush;
  assign push      = imem_valid && fetch_en && !flush;
  assign pop       = id_valid && id_ready;

  assign fifo_bus.push  = push;
  assign fifo_bus.pop   = pop;
  assign fifo_bus.clear = flush;
  assign fifo_bus.wdata = '{pc: pc_in, instr: imem_rdata};

  // Masking on id_valid keeps stale or X storage contents off the decode bus.
  assign id_instr  = id_valid ? fifo_bus.head.instr : NOP_INSTR;
  assign id_pc     = id_valid ? fifo_bus.head.pc    : '0;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_FULL;
          else if (pop && !push) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop)  state_d = ST_ONE;
        default:            state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!fetch_en) begin
        stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
    end
  end

endmodule
